// File: rtl/seq_multiplier_n.sv
// Sequential shift-add multiplier: one partial-product iteration per clock,
// unsigned or two's-complement operands, exact 2*WIDTH-bit result.
module seq_multiplier_n #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    // |x| as an unsigned WIDTH-bit value; the most negative input maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        logic [WIDTH-1:0] m;
        m = (sgn && x[WIDTH-1]) ? ('0 - x) : x;
        return m;
    endfunction

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                    mplier_d = magnitude(b, signed_mode);
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                // The last iteration's sum goes straight to product, sign-corrected.
                if (cnt_q == LAST) begin
                    product_d = neg_q ? ('0 - acc_sum) : acc_sum;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Randomised bench for seq_multiplier_n at WIDTH=32 and WIDTH=8, checked every
// cycle against a latency/arithmetic model plus literal expectations.
module tb_seq_multiplier_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b1;

    logic        start32 = 1'b0, s32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] product32;

    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;

    int checks = 0;
    int errors = 0;

    seq_multiplier_n #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(s32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .product(product32));

    seq_multiplier_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(s8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8));

    function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
        longint sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 64'(sx * sy);
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
        int sx, sy;
        if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            return 16'(sx * sy);
        end
        return {8'b0, x} * {8'b0, y};
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'h0;
            2: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Behavioural model: a start accepted while idle yields its product WIDTH edges later.
    logic        m32_busy = 0, m32_done = 0;
    logic [63:0] m32_prod = 0, m32_pend = 0;
    int          m32_left = 0;
    logic        m8_busy = 0, m8_done = 0;
    logic [15:0] m8_prod = 0, m8_pend = 0;
    int          m8_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32_busy <= 0; m32_done <= 0; m32_prod <= 0; m32_left <= 0;
            m8_busy  <= 0; m8_done  <= 0; m8_prod  <= 0; m8_left  <= 0;
        end else begin
            m32_done <= 0;
            if (m32_left > 0) begin
                m32_left <= m32_left - 1;
                if (m32_left == 1) begin
                    m32_busy <= 0; m32_done <= 1; m32_prod <= m32_pend;
                end
            end else if (start32) begin
                m32_pend <= ref32(a32, b32, s32); m32_left <= 32; m32_busy <= 1;
            end
            m8_done <= 0;
            if (m8_left > 0) begin
                m8_left <= m8_left - 1;
                if (m8_left == 1) begin
                    m8_busy <= 0; m8_done <= 1; m8_prod <= m8_pend;
                end
            end else if (start8) begin
                m8_pend <= ref8(a8, b8, s8); m8_left <= 8; m8_busy <= 1;
            end
        end
    end

    always @(negedge clk) begin
        checks++;
        if ({busy32, done32, product32} !== {m32_busy, m32_done, m32_prod}) begin
            errors++;
            $display("FAIL cycle32 @%0t: busy/done/product got %b/%b/%h expected %b/%b/%h",
                     $time, busy32, done32, product32, m32_busy, m32_done, m32_prod);
        end
        checks++;
        if ({busy8, done8, product8} !== {m8_busy, m8_done, m8_prod}) begin
            errors++;
            $display("FAIL cycle8 @%0t: busy/done/product got %b/%b/%h expected %b/%b/%h",
                     $time, busy8, done8, product8, m8_busy, m8_done, m8_prod);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Start one operation; inputs are scrambled and start re-pulsed while it runs.
    task automatic op32(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                        output int lat, output int nbusy);
        a32 = ia; b32 = ib; s32 = is; start32 = 1'b1;
        @(posedge clk); #2;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom; s32 = 1'($urandom);
        nbusy = busy32 ? 1 : 0;
        lat = 0;
        while (!done32 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy32) nbusy++;
            if (lat == 5) start32 = 1'b1;
            if (lat == 6) start32 = 1'b0;
        end
    endtask

    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic is,
                       output int lat);
        a8 = ia; b8 = ib; s8 = is; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
        lat = 0;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) start8 = 1'b1;
            if (lat == 4) start8 = 1'b0;
        end
    endtask

    initial begin
        int lat, nb, last, ndone;
        logic [31:0] ra, rb;
        logic        rs;
        logic [7:0]  ra8, rb8;

        chk("ref_pin_signed", ref32(32'hFFFF_FFFD, 32'h7, 1'b1), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("ref_pin_unsigned", ref32(32'hFFFF_FFFD, 32'h7, 1'b0), 64'h0000_0006_FFFF_FFEB);
        chk("ref_pin_8", {48'b0, ref8(8'h80, 8'h80, 1'b1)}, 64'h4000);

        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy", {63'b0, busy32}, 64'h0);
        chk("reset_done", {63'b0, done32}, 64'h0);
        chk("reset_product", product32, 64'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, nb);
        chk("max_unsigned_product", product32, 64'hFFFF_FFFE_0000_0001);
        chk("max_unsigned_latency", 64'(lat), 64'd32);
        chk("max_unsigned_busy_cycles", 64'(nb), 64'd32);

        op32(32'hFFFF_FFFD, 32'h7, 1'b1, lat, nb);
        chk("neg3x7_signed", product32, 64'hFFFF_FFFF_FFFF_FFEB);
        op32(32'hFFFF_FFFD, 32'h7, 1'b0, lat, nb);
        chk("neg3x7_unsigned", product32, 64'h0000_0006_FFFF_FFEB);

        op32(32'h0545_3FAF, 32'h0, 1'b0, lat, nb);
        chk("zero_operand_product", product32, 64'h0);
        chk("zero_operand_latency", 64'(lat), 64'd32);

        op8(8'h80, 8'h80, 1'b1, lat);
        chk("w8_min_x_min", {48'b0, product8}, 64'h4000);
        chk("w8_min_x_min_latency", 64'(lat), 64'd8);
        op8(8'h80, 8'h01, 1'b1, lat);
        chk("w8_min_x_one", {48'b0, product8}, 64'hFF80);
        chk("w8_min_x_one_latency", 64'(lat), 64'd8);

        // start held high: completions every WIDTH+1 cycles
        repeat (3) @(posedge clk);
        #2 start32 = 1'b1;
        last = -1; ndone = 0;
        for (int c = 0; c < 120; c++) begin
            @(posedge clk); #1;
            a32 = pick32(); b32 = pick32(); s32 = 1'($urandom);
            if (done32) begin
                if (last >= 0) chk("b2b_period", 64'(c - last), 64'd33);
                last = c;
                ndone++;
            end
        end
        start32 = 1'b0;
        chk("b2b_done_count", 64'(ndone), 64'd3);
        repeat (40) @(posedge clk);

        // reset in the middle of an operation
        #2 a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; s32 = 1'b0; start32 = 1'b1;
        @(posedge clk); #2 start32 = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_reset_busy", {63'b0, busy32}, 64'h0);
        chk("midrun_reset_done", {63'b0, done32}, 64'h0);
        chk("midrun_reset_product", product32, 64'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        chk("post_reset_product_held", product32, 64'h0);
        #2;
        op32(32'h0000_0013, 32'hFFFF_FFFE, 1'b1, lat, nb);
        chk("post_reset_op", product32, 64'hFFFF_FFFF_FFFF_FFDA);
        chk("post_reset_latency", 64'(lat), 64'd32);

        for (int i = 0; i < 30; i++) begin
            ra = pick32(); rb = pick32(); rs = 1'($urandom);
            op32(ra, rb, rs, lat, nb);
            chk("rand32_product", product32, ref32(ra, rb, rs));
            chk("rand32_latency", 64'(lat), 64'd32);
        end
        for (int i = 0; i < 30; i++) begin
            ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'($urandom);
            op8(ra8, rb8, rs, lat);
            chk("rand8_product", {48'b0, product8}, {48'b0, ref8(ra8, rb8, rs)});
            chk("rand8_latency", 64'(lat), 64'd8);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
